stq_drain: RTL and testbench

In-order drain engine for the 64-entry store queue. It tracks committed-but-not-written stores and reads their address-side attribute through the queue's two combinational read ports, up to two per cycle. It issues the stores to the L1 store-write port through a valid/ready output stage and returns freed-entry counts to the store-queue allocator. It is the reader and consumer of the per-entry address-data table that the store issue path writes.

---
 rtl/stq_pkg.sv | 37 +++
 rtl/stq_drain_pair.sv | 31 +++
 rtl/stq_drain.sv | 127 ++++++++++++
 tb/tb_stq_drain.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stq_pkg.sv
// Shared store-queue constants, types and helpers for the drain engine.
package stq_pkg;

    localparam int unsigned STQ_DEPTH      = 64;
    localparam int unsigned STQ_IDX_W      = 6;
    localparam int unsigned STQ_ADATA_W    = 5;
    localparam int unsigned STQ_CNT_W      = STQ_IDX_W + 1;
    localparam int unsigned ADATA_UC_BIT   = 4;
    localparam int unsigned ADATA_BANK_MSB = 3;
    localparam int unsigned ADATA_BANK_LSB = 0;

    typedef logic [STQ_IDX_W-1:0]   idx_t;
    typedef logic [STQ_ADATA_W-1:0] adata_t;
    typedef logic [STQ_CNT_W-1:0]   cnt_t;
    typedef logic [STQ_CNT_W:0]     cnt_ext_t;

    typedef enum logic [1:0] {
        IssueNone = 2'd0,
        IssueOne  = 2'd1,
        IssueTwo  = 2'd2
    } issue_e;

    typedef struct packed {
        logic   en;
        idx_t   wq;
        adata_t adata;
    } out_slot_t;

    function automatic logic is_uncached(input adata_t a);
        return a[ADATA_UC_BIT];
    endfunction

    function automatic logic bank_conflict(input adata_t a, input adata_t b);
        return a[ADATA_BANK_MSB:ADATA_BANK_LSB] == b[ADATA_BANK_MSB:ADATA_BANK_LSB];
    endfunction

endpackage

// File: rtl/stq_drain_pair.sv
// Decides how many committed stores (0..2) may issue together from the queue head.
module stq_drain_pair
    import stq_pkg::*;
(
    input  logic [STQ_CNT_W-1:0]   cmt,
    input  logic [STQ_ADATA_W-1:0] rd0_adata,
    input  logic [STQ_ADATA_W-1:0] rd1_adata,
    output logic [1:0]             n
);

    issue_e issue;

    // Uncached stores serialise: they never share a cycle with a neighbour.
    always_comb begin
        issue = IssueTwo;
        if (cmt == '0) begin
            issue = IssueNone;
        end else if (is_uncached(rd0_adata)) begin
            issue = IssueOne;
        end else if (cmt == cnt_t'(1)) begin
            issue = IssueOne;
        end else if (is_uncached(rd1_adata)) begin
            issue = IssueOne;
        end else if (bank_conflict(rd0_adata, rd1_adata)) begin
            issue = IssueOne;
        end
    end

    assign n = issue;

endmodule

// File: rtl/stq_drain.sv
// In-order store-queue drain: pairs committed stores from the head, issues them through a
// registered valid/ready stage to the L1 write port and reports freed entries to the allocator.
module stq_drain
    import stq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_en,
    input  logic [1:0]             commit_cnt,
    output logic [STQ_IDX_W-1:0]   rd0_WQ,
    input  logic [STQ_ADATA_W-1:0] rd0_adata,
    output logic [STQ_IDX_W-1:0]   rd1_WQ,
    input  logic [STQ_ADATA_W-1:0] rd1_adata,
    input  logic                   out_ready,
    output logic                   out0_en,
    output logic [STQ_IDX_W-1:0]   out0_WQ,
    output logic [STQ_ADATA_W-1:0] out0_adata,
    output logic                   out1_en,
    output logic [STQ_IDX_W-1:0]   out1_WQ,
    output logic [STQ_ADATA_W-1:0] out1_adata,
    output logic                   free_en,
    output logic [1:0]             free_cnt,
    output logic [STQ_IDX_W:0]     occ
);

    localparam cnt_ext_t MaxCmt = cnt_ext_t'(STQ_DEPTH);

    idx_t      head_q, head_d;
    cnt_t      cmt_q, cmt_d;
    cnt_ext_t  cmt_sum;
    out_slot_t slot0_q, slot0_d;
    out_slot_t slot1_q, slot1_d;
    logic      free_en_q, free_en_d;
    logic [1:0] free_cnt_q, free_cnt_d;

    logic       stalled;
    logic [1:0] pair_n;
    logic [1:0] n;
    idx_t       head_p1;

    assign head_p1 = head_q + idx_t'(1);
    assign rd0_WQ  = head_q;
    assign rd1_WQ  = head_p1;

    stq_drain_pair u_pair (
        .cmt       (cmt_q),
        .rd0_adata (rd0_adata),
        .rd1_adata (rd1_adata),
        .n         (pair_n)
    );

    assign stalled = slot0_q.en && !out_ready;
    assign n       = stalled ? 2'd0 : pair_n;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (!stalled) begin
            slot0_d = '0;
            slot1_d = '0;
            if (n != 2'd0) begin
                slot0_d = '{en: 1'b1, wq: head_q, adata: rd0_adata};
            end
            if (n == 2'd2) begin
                slot1_d = '{en: 1'b1, wq: head_p1, adata: rd1_adata};
            end
        end
    end

    // Index arithmetic wraps naturally at DEPTH since it is a power of two.
    assign head_d = head_q + idx_t'(n);

    // One extra bit so an over-commit is visible to the overflow check.
    always_comb begin
        cmt_sum = cnt_ext_t'(cmt_q) - cnt_ext_t'(n);
        if (commit_en) begin
            cmt_sum = cmt_sum + cnt_ext_t'(commit_cnt);
        end
        cmt_d = cmt_sum[STQ_CNT_W-1:0];
    end

    always_comb begin
        free_en_d  = slot0_q.en && out_ready;
        free_cnt_d = 2'd0;
        if (free_en_d) begin
            free_cnt_d = slot1_q.en ? 2'd2 : 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            cmt_q      <= '0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            free_en_q  <= 1'b0;
            free_cnt_q <= 2'd0;
        end else begin
            head_q     <= head_d;
            cmt_q      <= cmt_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            free_en_q  <= free_en_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign out0_en    = slot0_q.en;
    assign out0_WQ    = slot0_q.wq;
    assign out0_adata = slot0_q.adata;
    assign out1_en    = slot1_q.en;
    assign out1_WQ    = slot1_q.wq;
    assign out1_adata = slot1_q.adata;
    assign free_en    = free_en_q;
    assign free_cnt   = free_cnt_q;
    assign occ        = cmt_q;

    a_commit_cnt: assert property (@(posedge clk) disable iff (!rst)
        commit_en |-> commit_cnt != 2'd3);

    a_cmt_ovf: assert property (@(posedge clk) disable iff (!rst)
        cmt_sum <= MaxCmt);

    a_slot_order: assert property (@(posedge clk) disable iff (!rst)
        slot1_q.en |-> slot0_q.en);

endmodule

// File: tb/tb_stq_drain.sv
// Randomised and directed bench for stq_drain against a queue-level behavioural model.
module tb_stq_drain;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       commit_en = 1'b0;
    logic [1:0] commit_cnt = 2'd0;
    logic       out_ready = 1'b0;
    logic [5:0] rd0_WQ, rd1_WQ;
    logic [4:0] rd0_adata, rd1_adata;
    logic       out0_en, out1_en;
    logic [5:0] out0_WQ, out1_WQ;
    logic [4:0] out0_adata, out1_adata;
    logic       free_en;
    logic [1:0] free_cnt;
    logic [6:0] occ;

    logic [4:0] mem [64];

    int tests = 0;
    int fails = 0;

    // Behavioural model: queue head pointer, committed count, held output record, free report.
    int m_head = 0, m_cmt = 0;
    int m_o0en = 0, m_o0wq = 0, m_o0ad = 0;
    int m_o1en = 0, m_o1wq = 0, m_o1ad = 0;
    int m_fen = 0, m_fcnt = 0;

    always #5 clk = ~clk;

    assign rd0_adata = mem[rd0_WQ];
    assign rd1_adata = mem[rd1_WQ];

    stq_drain dut (
        .clk        (clk),
        .rst        (rst),
        .commit_en  (commit_en),
        .commit_cnt (commit_cnt),
        .rd0_WQ     (rd0_WQ),
        .rd0_adata  (rd0_adata),
        .rd1_WQ     (rd1_WQ),
        .rd1_adata  (rd1_adata),
        .out_ready  (out_ready),
        .out0_en    (out0_en),
        .out0_WQ    (out0_WQ),
        .out0_adata (out0_adata),
        .out1_en    (out1_en),
        .out1_WQ    (out1_WQ),
        .out1_adata (out1_adata),
        .free_en    (free_en),
        .free_cnt   (free_cnt),
        .occ        (occ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("rd0_WQ", 32'(rd0_WQ), m_head);
        check("rd1_WQ", 32'(rd1_WQ), (m_head + 1) % 64);
        check("occ", 32'(occ), m_cmt);
        check("out0_en", 32'(out0_en), m_o0en);
        check("out1_en", 32'(out1_en), m_o1en);
        check("free_en", 32'(free_en), m_fen);
        if (m_o0en != 0) begin
            check("out0_WQ", 32'(out0_WQ), m_o0wq);
            check("out0_adata", 32'(out0_adata), m_o0ad);
        end
        if (m_o1en != 0) begin
            check("out1_WQ", 32'(out1_WQ), m_o1wq);
            check("out1_adata", 32'(out1_adata), m_o1ad);
        end
        if (m_fen != 0) check("free_cnt", 32'(free_cnt), m_fcnt);
    endtask

    task automatic model_step(input bit r, input bit ce, input logic [1:0] cc, input bit rdy);
        int n;
        int nfen, nfcnt;
        logic [4:0] a0, a1;
        if (!r) begin
            m_head = 0; m_cmt = 0;
            m_o0en = 0; m_o0wq = 0; m_o0ad = 0;
            m_o1en = 0; m_o1wq = 0; m_o1ad = 0;
            m_fen = 0; m_fcnt = 0;
        end else begin
            n = 0;
            nfen = (m_o0en != 0 && rdy) ? 1 : 0;
            nfcnt = 1 + m_o1en;
            if (!(m_o0en != 0 && !rdy)) begin
                a0 = mem[m_head];
                a1 = mem[(m_head + 1) % 64];
                if (m_cmt == 0) n = 0;
                else if (a0[4]) n = 1;
                else if (m_cmt == 1) n = 1;
                else if (a1[4]) n = 1;
                else if (a0[3:0] == a1[3:0]) n = 1;
                else n = 2;
                m_o0en = (n > 0) ? 1 : 0;
                m_o0wq = m_head;
                m_o0ad = int'(a0);
                m_o1en = (n == 2) ? 1 : 0;
                m_o1wq = (m_head + 1) % 64;
                m_o1ad = int'(a1);
            end
            if (ce) m_cmt += int'(cc);
            m_cmt -= n;
            m_head = (m_head + n) % 64;
            m_fen = nfen;
            m_fcnt = nfcnt;
        end
    endtask

    // Inputs change at the falling edge; the model advances on the rising edge; outputs are
    // compared at the next falling edge.
    task automatic cycle(input bit r, input bit ce, input logic [1:0] cc, input bit rdy);
        rst = r; commit_en = ce; commit_cnt = cc; out_ready = rdy;
        @(posedge clk);
        model_step(r, ce, cc, rdy);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((m_cmt != 0 || m_o0en != 0 || m_fen != 0) && k < 300) begin
            cycle(1'b1, 1'b0, 2'd0, 1'b1);
            k++;
        end
        if (k >= 300) check(name, 32'd1, 32'd0);
    endtask

    function automatic logic [4:0] rand_adata();
        logic [4:0] a;
        a[4] = ($urandom_range(0, 7) == 0);
        a[3:0] = 4'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        int bias;
        logic [1:0] cc;
        bit ce, rdy, r;

        for (int i = 0; i < 64; i++) mem[i] = 5'h00;

        // Pair issue with distinct banks.
        mem[0] = 5'h01; mem[1] = 5'h02;
        @(negedge clk);
        do_reset();
        check("rst_out0_en", 32'(out0_en), 0);
        check("rst_occ", 32'(occ), 0);
        check("rst_free_en", 32'(free_en), 0);
        cycle(1'b1, 1'b1, 2'd2, 1'b1);
        check("t1_occ2", 32'(occ), 2);
        check("t1_no_issue_yet", 32'(out0_en), 0);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t1_out0_en", 32'(out0_en), 1);
        check("t1_out0_WQ", 32'(out0_WQ), 0);
        check("t1_out1_en", 32'(out1_en), 1);
        check("t1_out1_WQ", 32'(out1_WQ), 1);
        check("t1_occ0", 32'(occ), 0);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t1_free_en", 32'(free_en), 1);
        check("t1_free_cnt", 32'(free_cnt), 2);

        // Bank conflict splits the pair.
        mem[0] = 5'h03; mem[1] = 5'h03;
        do_reset();
        cycle(1'b1, 1'b1, 2'd2, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t2_out0_WQ0", 32'(out0_WQ), 0);
        check("t2_out1_en", 32'(out1_en), 0);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t2_out0_WQ1", 32'(out0_WQ), 1);
        check("t2_free_cnt_a", 32'(free_cnt), 1);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t2_free_en_b", 32'(free_en), 1);
        check("t2_free_cnt_b", 32'(free_cnt), 1);

        // Uncached head issues alone.
        mem[0] = 5'h10; mem[1] = 5'h01; mem[2] = 5'h02; mem[3] = 5'h03;
        do_reset();
        cycle(1'b1, 1'b1, 2'd2, 1'b1);
        cycle(1'b1, 1'b1, 2'd2, 1'b1);
        check("t3_out0_en", 32'(out0_en), 1);
        check("t3_out1_en", 32'(out1_en), 0);
        check("t3_occ3", 32'(occ), 3);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t3_next_WQ", 32'(out0_WQ), 1);
        check("t3_next_pair", 32'(out1_en), 1);
        drain("t3_drain_timeout");

        // Back-pressure holds the output stage.
        mem[0] = 5'h01; mem[1] = 5'h02; mem[2] = 5'h04; mem[3] = 5'h05;
        do_reset();
        cycle(1'b1, 1'b1, 2'd2, 1'b0);
        cycle(1'b1, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 1'b1, 2'd1, 1'b0);
        cycle(1'b1, 1'b1, 2'd1, 1'b0);
        cycle(1'b1, 1'b0, 2'd0, 1'b0);
        check("t4_hold_en", 32'(out0_en), 1);
        check("t4_hold_WQ0", 32'(out0_WQ), 0);
        check("t4_hold_WQ1", 32'(out1_WQ), 1);
        check("t4_head", 32'(rd0_WQ), 2);
        check("t4_occ", 32'(occ), 2);
        check("t4_no_free", 32'(free_en), 0);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t4_free_en", 32'(free_en), 1);
        check("t4_free_cnt", 32'(free_cnt), 2);
        check("t4_new_WQ0", 32'(out0_WQ), 2);
        check("t4_new_WQ1", 32'(out1_WQ), 3);
        drain("t4_drain_timeout");

        // Wrap from 63 to 0.
        for (int i = 0; i < 64; i++) mem[i] = 5'h00;
        do_reset();
        for (int i = 0; i < 31; i++) cycle(1'b1, 1'b1, 2'd2, 1'b1);
        cycle(1'b1, 1'b1, 2'd1, 1'b1);
        drain("t5_drain_timeout");
        check("t5_head63", 32'(rd0_WQ), 63);
        mem[63] = 5'h01; mem[0] = 5'h02;
        cycle(1'b1, 1'b1, 2'd2, 1'b1);
        cycle(1'b1, 1'b0, 2'd0, 1'b0);
        check("t5_out0_WQ", 32'(out0_WQ), 63);
        check("t5_out1_WQ", 32'(out1_WQ), 0);
        check("t5_out1_en", 32'(out1_en), 1);
        check("t5_head1", 32'(rd0_WQ), 1);

        // Reset while stalled.
        cycle(1'b1, 1'b1, 2'd2, 1'b0);
        check("t6_stalled", 32'(out0_en), 1);
        cycle(1'b0, 1'b0, 2'd0, 1'b0);
        check("t6_out0_en", 32'(out0_en), 0);
        check("t6_out1_en", 32'(out1_en), 0);
        check("t6_out0_WQ", 32'(out0_WQ), 0);
        check("t6_out0_adata", 32'(out0_adata), 0);
        check("t6_occ", 32'(occ), 0);
        check("t6_free_en", 32'(free_en), 0);
        cycle(1'b1, 1'b0, 2'd0, 1'b1);
        check("t6_no_free", 32'(free_en), 0);

        // Randomised traffic with varying back-pressure and occasional reset.
        for (int i = 0; i < 64; i++) mem[i] = rand_adata();
        bias = 90;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) bias = (c / 500) % 3 == 0 ? 90 : ((c / 500) % 3 == 1 ? 25 : 60);
            mem[$urandom_range(0, 63)] = rand_adata();
            ce = ($urandom_range(0, 3) != 0);
            cc = 2'($urandom_range(0, 2));
            if (m_cmt + int'(cc) > 64) cc = 2'(64 - m_cmt);
            rdy = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 399) != 0);
            cycle(r, ce, cc, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
